bch_encode: RTL and testbench

Systematic serial BCH encoder for an (N, K, T) binary BCH code; the upstream counterpart of the serial decoder. It accepts K message bits one per clock, forwards them unchanged, then appends N-K parity bits computed by a generator-polynomial LFSR. The result is a continuous one-bit-per-clock codeword stream with a valid strobe. `dout`/`vdout` connect directly to the decoder's `din` input, through the channel or error-injection logic.

---
 rtl/bch_encode.sv | 114 +++++++++++
 tb/tb_bch_encode.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bch_encode.sv
// bch_encode: systematic serial BCH encoder.
// Accepts K message bits one per clock and forwards them unchanged. It then
// appends N-K parity bits from a generator-polynomial LFSR. The output is a
// one-bit-per-clock codeword stream with a valid strobe, one cycle behind din.
`timescale 1ns/1ps

module bch_encode #(
    parameter int       N   = 15,
    parameter int       K   = 5,
    parameter int       T   = 3,
    parameter logic [N-K:0] GEN = 11'h537
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic din,
    output logic ready,
    output logic vdout,
    output logic dout
);

    localparam int             P     = N - K;
    localparam int             CW    = $clog2(N);
    localparam logic [CW-1:0]  LAST  = CW'(N - 1);
    localparam logic [CW-1:0]  KCNT  = CW'(K);

    // Reject parameter sets that cannot describe a valid code.
    if (K < 1 || K >= N || GEN[N-K] != 1'b1 || T < 1 || (2 * T + 1) > N) begin : g_param_err
        $error("bch_encode: illegal N/K/T/GEN combination");
    end

    // One LFSR step of division by g(x), feeding in one message bit.
    function automatic logic [P-1:0] lfsr_step(input logic [P-1:0] par, input logic bit_in);
        logic fb;
        fb = bit_in ^ par[P-1];
        return (par << 1) ^ (fb ? GEN[P-1:0] : '0);
    endfunction

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [P-1:0]  r_par;
    logic          r_vdout;
    logic          r_dout;

    logic          w_last;
    logic          w_accept;
    logic          w_msg_phase;
    logic          w_busy_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [P-1:0]  w_par_nxt;
    logic          w_vdout_nxt;
    logic          w_dout_nxt;

    // ready depends only on registered state, so start cannot loop back into it.
    assign w_last   = r_busy && (r_cnt == LAST);
    assign ready    = !r_busy || w_last;
    assign w_accept = start && ready;
    assign w_msg_phase = r_busy && (r_cnt < KCNT);

    // Next-state selection: new word, message bit, parity bit, or idle.
    always_comb begin
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_vdout_nxt = 1'b0;
        w_dout_nxt  = 1'b0;
        if (w_accept) begin
            // New word: the LFSR restarts from zero, and any old residue is dropped.
            // On a back-to-back start, the last parity bit of the old word
            // still goes out this cycle.
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_par_nxt   = lfsr_step('0, din);
            w_vdout_nxt = 1'b1;
            w_dout_nxt  = w_last ? r_par[P-1] : din;
        end else if (r_busy) begin
            w_vdout_nxt = 1'b1;
            if (w_msg_phase) begin
                w_par_nxt  = lfsr_step(r_par, din);
                w_dout_nxt = din;
            end else begin
                w_par_nxt  = r_par << 1;
                w_dout_nxt = r_par[P-1];
            end
            if (w_last) begin
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt  = r_cnt + 1'b1;
            end
        end
    end

    // State and output registers; reset truncates any word in flight at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_par   <= '0;
            r_vdout <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_vdout <= w_vdout_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    assign vdout = r_vdout;
    assign dout  = r_dout;

endmodule

// File: tb/tb_bch_encode.sv
// tb_bch_encode: scoreboard bench for bch_encode.
// The stimulus queues the expected codeword bits, each tagged with the cycle
// on which it must appear. The monitor checks dout/vdout on every falling edge.
`timescale 1ns/1ps

module tb_bch_encode;

    localparam int N = 15;
    localparam int K = 5;
    localparam int T = 3;
    localparam int P = N - K;
    localparam logic [P:0] GEN = 11'h537;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic din   = 1'b0;
    logic ready;
    logic vdout;
    logic dout;

    bch_encode #(.N(N), .K(K), .T(T), .GEN(GEN)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .ready (ready),
        .vdout (vdout),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: systematic codeword = m(x)*x^P + (m(x)*x^P mod g(x)), by long division.
    function automatic logic [N-1:0] ref_cw(input logic [K-1:0] m);
        logic [N-1:0] shifted;
        logic [N-1:0] rem;
        logic [N-1:0] g;
        shifted = N'(m) << P;
        rem     = shifted;
        g       = N'(GEN);
        for (int i = N - 1; i >= P; i--) begin
            if (rem[i]) rem = rem ^ (g << (i - P));
        end
        return shifted | rem;
    endfunction

    task automatic push_word(input logic [N-1:0] cw, input int c0);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.b   = cw[N-1-i];
            e.due = c0 + 1 + i;
            sb.push_back(e);
        end
    endtask

    // Monitor: every cycle, either the next expected bit is due or the output must be idle.
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("vdout_word", 32'(vdout), 32'd1);
                check("dout_bit", 32'(dout), 32'(sb[0].b));
                void'(sb.pop_front());
            end else begin
                check("vdout_idle", 32'(vdout), 32'd0);
            end
        end
    end

    // Drive one word from its start cycle. p1/p2 are cycles with ignored start
    // pulses, rst_at is a cycle where reset hits (-1 means none), and gap is
    // the number of idle cycles afterwards.
    task automatic run_word(input logic [K-1:0] m, input logic [N-1:0] cw,
                            input int p1, input int p2, input int rst_at, input int gap);
        check("ready_idle", 32'(ready), 32'd1);
        start = 1'b1;
        din   = m[K-1];
        push_word(cw, cyc);
        @(posedge clk); #1;
        for (int c = 1; c < N; c++) begin
            if (c == rst_at) begin
                reset = 1'b0;
                start = 1'b0;
                sb.delete();
                #1;
                check("rst_vdout", 32'(vdout), 32'd0);
                check("rst_dout", 32'(dout), 32'd0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
            start = (c == p1) || (c == p2);
            din   = (c < K) ? m[K-1-c] : 1'($urandom);
            check("ready_busy", 32'(ready), 32'(c == N - 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (gap) begin
            din = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [K-1:0] m;
        int p1;
        int rst_at;
        int gap;

        repeat (3) @(posedge clk);
        #1;
        check("reset_vdout", 32'(vdout), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed words with known codewords.
        run_word(5'b00001, 15'h0537, -1, -1, -1, 2);
        run_word(5'b10100, 15'h5370, -1, -1, -1, 2);
        run_word(5'b11111, 15'h7FFF, -1, -1, -1, 2);
        run_word(5'b00000, 15'h0000, -1, -1, -1, 2);

        // Back-to-back: these three words must form one unbroken valid run.
        run_word(5'b00001, 15'h0537, -1, -1, -1, 0);
        run_word(5'b10100, 15'h5370, -1, -1, -1, 0);
        run_word(5'b11111, 15'h7FFF, -1, -1, -1, 3);

        // Start pulses in the middle of a word are ignored.
        run_word(5'b00001, 15'h0537, 3, 10, -1, 2);

        // Reset at cnt=7, then a clean word with no leftover parity.
        run_word(5'b00001, 15'h0537, -1, -1, 7, 0);
        run_word(5'b00001, 15'h0537, -1, -1, -1, 2);

        // Random messages, gaps, ignored pulses and occasional resets.
        for (int w = 0; w < 300; w++) begin
            m      = K'($urandom);
            p1     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N - 2)) : -1;
            rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, N - 1)) : -1;
            gap    = int'($urandom_range(0, 3));
            run_word(m, ref_cw(m), p1, -1, rst_at, gap);
        end

        repeat (N + 2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
